muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//   Iterative RV32M multiply/divide unit, downstream of the register file.
//   Takes the two register read operands (data1/data2) plus the destination index.
//   Produces a write-back record (rd, data) for the register-file write port.
//   Shift-add multiply, restoring divide; one result bit per cycle.
//   Valid/ready handshake on both sides so the core can stall around it.
// PARAMETERS
//   DATA_WIDTH  32  operand/result width (>=8)
//   ADDR_WIDTH  5   register index width, matches register file
// PORTS
//   clk        in   1           clock, all state on posedge
//   rst_n      in   1           synchronous reset, active low
//   in_valid   in   1           operation request
//   in_ready   out  1           unit idle, request accepted when in_valid&in_ready
//   in_op      in   3           RV32M funct3: 0 MUL 1 MULH 2 MULHSU 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU
//   in_src1    in   DATA_WIDTH  rs1 value (register file data1)
//   in_src2    in   DATA_WIDTH  rs2 value (register file data2)
//   in_rd      in   ADDR_WIDTH  destination register index
//   flush      in   1           abandon any in-flight operation
//   out_valid  out  1           result available
//   out_ready  in   1           write-back accepts result when out_valid&out_ready
//   out_rd     out  ADDR_WIDTH  destination index for register file rd
//   out_data   out  DATA_WIDTH  result for register file dataD
// BEHAVIOUR
//   - One clock (clk); reset is synchronous, active-low (rst_n).
//   - Reset and flush both force IDLE with out_valid=0, out_rd=0, out_data=0 and counter=0.
//     This applies mid-operation too. in_ready=1 in the cycle after reset or flush.
//   - States:
//     - IDLE: in_ready=1. Accept moves to MUL (op 0-3) or DIV (op 4-7).
//       A special-case divide instead moves to DONE.
//     - MUL/DIV: in_ready=0. Counter runs 0..DATA_WIDTH-1; moves to DONE after the last step.
//     - DONE: out_valid=1. On out_ready, go to IDLE; no same-cycle re-accept.
//   - Latency: accept in cycle T.
//     - Normal op: out_valid from cycle T+DATA_WIDTH+1.
//     - Special-case divide: out_valid from cycle T+1.
//   - Operands, op and rd are latched at accept. Later input changes have no effect.
//   - out_rd/out_data are stable while out_valid & !out_ready. They update only at DONE entry.
//   - Multiply: operands sign-extended per op to 2*DATA_WIDTH.
//     - MULH: both signed. MULHSU: src1 signed, src2 unsigned. MULHU and MUL: unsigned.
//     - MUL returns the low half; MULH/MULHSU/MULHU return the high half.
//   - Divide: magnitudes via restoring algorithm.
//     - Quotient sign = sign1^sign2.
//     - Remainder sign = sign of dividend (truncating division).
//   - Special cases, resolved at accept with no iteration:
//     - divisor==0: DIV/DIVU -> all ones; REM/REMU -> src1.
//     - DIV/REM with src1=most-negative and src2=-1: DIV -> src1; REM -> 0.
//   - in_rd==0 is processed normally. out_rd=0 is emitted; the register file discards it.
//   - flush and in_valid in the same cycle: flush wins, nothing is accepted.
//   - flush in DONE drops the result.
// TESTING (DATA_WIDTH=32)
//   - MUL 7 x 0xFFFFFFFD, out_ready=1 -> out_data=0xFFFFFFEB, out_valid first at T+33, out_rd = latched rd.
//   - High-half multiplies:
//     - MULH 0x80000000 x 0x80000000 -> 0x40000000.
//     - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
//     - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
//   - Divides:
//     - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD.
//     - REM 0xFFFFFFF9 / 2 -> 0xFFFFFFFF.
//     - DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2. All at T+33.
//   - Special cases, all with out_valid at T+1:
//     - DIV 5 / 0 -> 0xFFFFFFFF; REM 5 / 0 -> 5.
//     - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM 0x80000000 / 0xFFFFFFFF -> 0.
//   - Backpressure: out_ready=0 for 5 cycles in DONE.
//     -> out_data/out_rd constant and in_ready=0 throughout.
//     -> After the handshake, in_ready=1 the next cycle.
//   - Abort: flush at T+10 of a DIV -> out_valid never rises, in_ready=1 at T+11.
//     - Same check with rst_n=0 at T+10.
//     - A new MUL accepted afterwards returns the correct result.

Source files
------------

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M multiply/divide unit sitting behind the register file.
//   The multiply uses shift-add and the divide uses restoring division. Each
//   produces one result bit per cycle. Divide-by-zero and signed overflow
//   are resolved at accept time and skip the iteration entirely.
//
// Ports
//   clk        clock, all state on posedge
//   rst_n      synchronous reset, active low
//   in_valid   operation request
//   in_ready   unit idle; request accepted when in_valid & in_ready
//   in_op      RV32M funct3 (0 MUL .. 7 REMU)
//   in_src1    rs1 operand
//   in_src2    rs2 operand
//   in_rd      destination register index
//   flush      abandon any in-flight operation or pending result
//   out_valid  result available
//   out_ready  write-back accepts result when out_valid & out_ready
//   out_rd     destination index of the result
//   out_data   result value
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_op,
    input  logic [DATA_WIDTH-1:0] in_src1,
    input  logic [DATA_WIDTH-1:0] in_src2,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_rd,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST     = CW'(DATA_WIDTH - 1);
    localparam logic [W-1:0]  ALL_ONES = {W{1'b1}};
    localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [1:0]      op_lo;      // op[2] is implied by the MUL/DIV state
    logic [ADDR_WIDTH-1:0] rd_q;
    logic            mul_neg_b;  // multiplier is signed: last partial product subtracts
    logic            neg_quo;
    logic            neg_rem;
    logic [2*W-1:0]  acc;        // product accumulator; low half is the remainder in divide
    logic [2*W-1:0]  mcand;      // sign/zero-extended multiplicand, shifted left each step
    logic [W-1:0]    mplier;     // multiplier bits (shift right) or dividend -> quotient (shift left)
    logic [W-1:0]    divisor;

    // Accept-time decode
    logic            div_op, div_signed, sign1, sign2;
    logic [W-1:0]    mag1, mag2;
    logic            div_by_zero, div_ovf, is_special;
    logic [W-1:0]    special_res;

    // One iteration step
    logic [2*W-1:0]  mul_addend, mul_next;
    logic [W:0]      div_shift, div_diff;
    logic            div_ge;
    logic [W-1:0]    div_rem, div_quo;
    logic [W-1:0]    mul_result, div_result;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        div_op      = in_op[2];
        div_signed  = ~in_op[0];
        sign1       = 1'b0;
        sign2       = 1'b0;
        if (div_op) begin
            sign1 = in_src1[W-1] & div_signed;
            sign2 = in_src2[W-1] & div_signed;
        end else begin
            sign1 = in_src1[W-1] & ((in_op == 3'd1) || (in_op == 3'd2));
            sign2 = in_src2[W-1] & (in_op == 3'd1);
        end
        mag1        = sign1 ? -in_src1 : in_src1;
        mag2        = sign2 ? -in_src2 : in_src2;
        div_by_zero = (in_src2 == '0);
        div_ovf     = div_signed && (in_src1 == MOST_NEG) && (in_src2 == ALL_ONES);
        is_special  = div_op & (div_by_zero | div_ovf);
        // in_op[1] selects the remainder flavour
        if (div_by_zero) special_res = in_op[1] ? in_src1 : ALL_ONES;
        else             special_res = in_op[1] ? '0      : in_src1;

        // Signed multiplier: its top bit carries weight -2^(W-1), so the final
        // partial product is subtracted instead of added.
        mul_addend = mplier[0] ? mcand : '0;
        mul_next   = (mul_neg_b && (count == LAST)) ? acc - mul_addend : acc + mul_addend;

        // Restoring step: bring in the next dividend bit, keep the difference if it fits.
        div_shift  = {acc[W-1:0], mplier[W-1]};
        div_diff   = div_shift - {1'b0, divisor};
        div_ge     = ~div_diff[W];
        div_rem    = div_ge ? div_diff[W-1:0] : div_shift[W-1:0];
        div_quo    = {mplier[W-2:0], div_ge};

        mul_result = (op_lo == 2'd0) ? mul_next[W-1:0] : mul_next[2*W-1:W];
        if (op_lo[1]) div_result = neg_rem ? -div_rem : div_rem;
        else          div_result = neg_quo ? -div_quo : div_quo;
    end

    // NOTE: datapath registers are left out of the reset branch; they are only
    // read in MUL/DIV, and every path into those states loads them first.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register sees the pre-edge value of every other register.
        if (!rst_n || flush) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_rd    <= '0;
            out_data  <= '0;
            count     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        op_lo    <= in_op[1:0];
                        rd_q     <= in_rd;
                        count    <= '0;
                        acc      <= '0;
                        if (is_special) begin
                            out_data  <= special_res;
                            out_rd    <= in_rd;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end else if (div_op) begin
                            mplier  <= mag1;
                            divisor <= mag2;
                            neg_quo <= sign1 ^ sign2;
                            neg_rem <= sign1;
                            state   <= S_DIV;
                        end else begin
                            mcand     <= {{W{sign1}}, in_src1};
                            mplier    <= in_src2;
                            mul_neg_b <= sign2;
                            state     <= S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    acc    <= mul_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CW'(1);
                    if (count == LAST) begin
                        out_data  <= mul_result;
                        out_rd    <= rd_q;
                        out_valid <= 1'b1;
                        count     <= '0;
                        state     <= S_DONE;
                    end
                end
                S_DIV: begin
                    acc    <= {{W{1'b0}}, div_rem};
                    mplier <= div_quo;
                    count  <= count + CW'(1);
                    if (count == LAST) begin
                        out_data  <= div_result;
                        out_rd    <= rd_q;
                        out_valid <= 1'b1;
                        count     <= '0;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Result held until taken; re-accept only from IDLE next cycle.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Self-checking bench for muldiv_unit (DATA_WIDTH=32). Directed cases with
//   hand-derived results, abort/backpressure scenarios, then randomized
//   operations checked against a plain-arithmetic RV32M reference model.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int W = 32;
    localparam int A = 5;
    localparam logic [W-1:0] MOST_NEG = 32'h8000_0000;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_op;
    logic [W-1:0] in_src1;
    logic [W-1:0] in_src2;
    logic [A-1:0] in_rd;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [A-1:0] out_rd;
    logic [W-1:0] out_data;

    int n_tests = 0;
    int n_fail  = 0;

    muldiv_unit #(.DATA_WIDTH(W), .ADDR_WIDTH(A)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_src1   (in_src1),
        .in_src2   (in_src2),
        .in_rd     (in_rd),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rd    (out_rd),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference RV32M semantics from plain 64-bit arithmetic.
    function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0]        ua, ub, p;
        logic [W-1:0]       r;
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = '0;
        r  = '0;
        case (op)
            3'd0: begin p = ua * ub; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * $signed(ub); r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = '1;
                else if (a == MOST_NEG && b == '1) r = a;
                else r = $signed(a) / $signed(b);
            end
            3'd5: r = (b == 0) ? '1 : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == MOST_NEG && b == '1) r = '0;
                else r = $signed(a) % $signed(b);
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic bit is_special(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        if (op < 3'd4) return 1'b0;
        if (b == 0) return 1'b1;
        return (op == 3'd4 || op == 3'd6) && a == MOST_NEG && b == '1;
    endfunction

    // Issue one operation, check latency/result/rd, hold out_ready low for
    // 'stall' cycles checking stability, then hand the result off.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [A-1:0] rd,
                          input logic [W-1:0] exp, input int stall, input bit early_ready);
        int lat, waited, bad;
        int exp_lat;
        logic [W-1:0] held_data;
        logic [A-1:0] held_rd;
        exp_lat = is_special(op, a, b) ? 1 : W + 1;
        waited = 0;
        while (!in_ready && waited < 100) begin @(negedge clk); waited++; end
        check({tag, "_idle"}, in_ready, 1'b1);
        in_valid  = 1'b1;
        in_op     = op;
        in_src1   = a;
        in_src2   = b;
        in_rd     = rd;
        out_ready = early_ready;
        @(posedge clk);
        @(negedge clk);
        // Scramble inputs: the unit must have latched them at accept.
        in_valid = 1'b0;
        in_op    = 3'($urandom);
        in_src1  = $urandom;
        in_src2  = $urandom;
        in_rd    = 5'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_data"}, out_data, exp);
        check({tag, "_rd"}, out_rd, rd);
        if (!early_ready) begin
            held_data = out_data;
            held_rd   = out_rd;
            bad = 0;
            repeat (stall) begin
                @(negedge clk);
                if (!out_valid || in_ready || out_data !== held_data || out_rd !== held_rd) bad++;
            end
            if (stall > 0) check({tag, "_hold"}, bad, 0);
            out_ready = 1'b1;
        end
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_release"}, {out_valid, in_ready}, 2'b01);
    endtask

    task automatic quiet(input string tag, input int cycles);
        int bad;
        bad = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        check(tag, bad, 0);
    endtask

    // Start a DIV, abort it in cycle T+10 via flush or reset.
    task automatic abort_div(input string tag, input bit use_reset);
        in_valid = 1'b1;
        in_op    = 3'd4;
        in_src1  = 32'd1000;
        in_src2  = 32'd3;
        in_rd    = 5'd9;
        @(posedge clk);
        @(negedge clk);              // cycle T+1
        in_valid = 1'b0;
        repeat (9) @(negedge clk);   // cycle T+10
        if (use_reset) rst_n = 1'b0; else flush = 1'b1;
        @(negedge clk);              // cycle T+11
        rst_n = 1'b1;
        flush = 1'b0;
        check({tag, "_ready"}, in_ready, 1'b1);
        check({tag, "_clear"}, {out_valid, out_rd, out_data}, '0);
        quiet({tag, "_quiet"}, 40);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]   op;
        logic [W-1:0] a, b;
        logic [A-1:0] rd;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_src1   = '0;
        in_src2   = '0;
        in_rd     = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset_ready", in_ready, 1'b1);
        check("reset_outs", {out_valid, out_rd, out_data}, '0);

        // Directed cases with hand-derived results
        run_op("mul",    3'd0, 32'd7,        32'hFFFF_FFFD, 5'd17, 32'hFFFF_FFEB, 0, 1'b1);
        run_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 5'd3, 32'h4000_0000, 0, 1'b0);
        run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, 0, 1'b0);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFF, 0, 1'b0);
        run_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2,         5'd6, 32'hFFFF_FFFD, 0, 1'b0);
        run_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2,         5'd7, 32'hFFFF_FFFF, 0, 1'b0);
        run_op("divu",   3'd5, 32'd100,       32'd7,         5'd8, 32'd14,        0, 1'b0);
        run_op("remu",   3'd7, 32'd100,       32'd7,         5'd0, 32'd2,         0, 1'b0);
        run_op("div0",   3'd4, 32'd5,         32'd0,         5'd10, 32'hFFFF_FFFF, 0, 1'b0);
        run_op("rem0",   3'd6, 32'd5,         32'd0,         5'd11, 32'd5,        0, 1'b0);
        run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 0, 1'b0);
        run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0,        0, 1'b0);
        run_op("bp",     3'd5, 32'd1234567,   32'd89,        5'd14, 32'd13871,    5, 1'b0);

        // Aborts, then a fresh multiply must still work
        abort_div("flush_abort", 1'b0);
        abort_div("reset_abort", 1'b1);
        run_op("post_abort", 3'd0, 32'd12345, 32'd6789, 5'd21, 32'd83810205, 0, 1'b0);

        // flush together with in_valid: nothing accepted
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; in_op = 3'd0; in_src1 = 32'd3; in_src2 = 32'd4;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("flush_vs_valid_ready", in_ready, 1'b1);
        quiet("flush_vs_valid_quiet", 40);

        // flush while a result waits in DONE drops it
        in_valid = 1'b1; in_op = 3'd5; in_src1 = 32'd9; in_src2 = 32'd0; in_rd = 5'd2;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("done_flush_pre", out_valid, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("done_flush_drop", {out_valid, in_ready}, 2'b01);

        // Randomized operations against the reference model
        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            rd = 5'($urandom);
            case ($urandom_range(0, 7))
                0: b = '0;
                1: begin a = MOST_NEG; b = '1; end
                2: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
                3: b = -32'($urandom_range(1, 20));
                default: ;
            endcase
            run_op($sformatf("rand%0d_op%0d", i, op), op, a, b, rd, model(op, a, b),
                   $urandom_range(0, 3), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
